param_up_down_counter: RTL and testbench

- Synchronous, parametrised up/down counter. Successor to the fixed 4-bit ripple counters in the counters library.
- Single clock domain, no ripple clocking.
- Adds programmable width and modulus, run-time direction, count enable, parallel load, and a registered terminal-count pulse.
- Used as a general event/timer counter in small-scale projects.

---
 rtl/param_up_down_counter.sv | 86 ++++++++
 tb/tb_param_up_down_counter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/param_up_down_counter.sv
`default_nettype none
// ============================================================================
// Module   : param_up_down_counter
// Purpose  : Synchronous up/down counter with programmable width and modulus,
//            count enable, clamped parallel load and registered terminal count.
//            Define PARAM_COUNTER_SATURATE_EN to saturate at the boundaries
//            instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module param_up_down_counter #(
    parameter int WIDTH     = 4,
    parameter int MODULUS   = 16,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             zero
);

    localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] c_RST = WIDTH'(RESET_VAL);
    // One extra bit so MODULUS == 2**WIDTH is representable for the clamp test.
    localparam logic [WIDTH:0]   c_MOD = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] r_q;
    logic             r_tc;
    logic [WIDTH-1:0] w_next_q;
    logic             w_next_tc;
    logic             w_load_ok;

    assign w_load_ok = ({1'b0, load_val} < c_MOD);

    always_comb begin
        w_next_q  = r_q;
        w_next_tc = 1'b0;
        if (load) begin
            w_next_q = w_load_ok ? load_val : c_MAX;
        end else if (en) begin
            if (up_dn) begin
                if (r_q == c_MAX) begin
`ifdef PARAM_COUNTER_SATURATE_EN
                    w_next_q  = c_MAX;
`else
                    w_next_q  = '0;
`endif
                    w_next_tc = 1'b1;
                end else begin
                    w_next_q = r_q + WIDTH'(1);
                end
            end else begin
                if (r_q == '0) begin
`ifdef PARAM_COUNTER_SATURATE_EN
                    w_next_q  = '0;
`else
                    w_next_q  = c_MAX;
`endif
                    w_next_tc = 1'b1;
                end else begin
                    w_next_q = r_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q  <= c_RST;
            r_tc <= 1'b0;
        end else begin
            r_q  <= w_next_q;
            r_tc <= w_next_tc;
        end
    end

    assign q    = r_q;
    assign tc   = r_tc;
    assign zero = (r_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_param_up_down_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_up_down_counter
// Purpose  : Scoreboard bench for three counter configurations (mod 10, mod 8,
//            mod 2); expectations follow PARAM_COUNTER_SATURATE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_up_down_counter;

`ifdef PARAM_COUNTER_SATURATE_EN
    localparam bit c_SAT = 1'b1;
`else
    localparam bit c_SAT = 1'b0;
`endif

    typedef struct {
        int         sel;
        logic [3:0] q;
        logic       tc;
        string      nm;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic       en10, up10, ld10;
    logic [3:0] lv10, q10;
    logic       tc10, z10;
    logic       en8, up8, ld8;
    logic [2:0] lv8, q8;
    logic       tc8, z8;
    logic       en2, up2, ld2;
    logic [0:0] lv2, q2;
    logic       tc2, z2;

    param_up_down_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) u_dut10 (
        .clk(clk), .reset_n(reset_n), .en(en10), .up_dn(up10), .load(ld10),
        .load_val(lv10), .q(q10), .tc(tc10), .zero(z10));
    param_up_down_counter #(.WIDTH(3), .MODULUS(8), .RESET_VAL(0)) u_dut8 (
        .clk(clk), .reset_n(reset_n), .en(en8), .up_dn(up8), .load(ld8),
        .load_val(lv8), .q(q8), .tc(tc8), .zero(z8));
    param_up_down_counter #(.WIDTH(1), .MODULUS(2), .RESET_VAL(1)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .en(en2), .up_dn(up2), .load(ld2),
        .load_val(lv2), .q(q2), .tc(tc2), .zero(z2));

    exp_t       sb[$];
    exp_t       mon_item;
    logic [3:0] aq;
    logic       atc, az;
    int         total = 0;
    int         bad   = 0;

    // Monitor: every negedge after a stimulus cycle, pop and compare.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_item = sb.pop_front();
            case (mon_item.sel)
                0:       begin aq = q10;              atc = tc10; az = z10; end
                1:       begin aq = {1'b0, q8};       atc = tc8;  az = z8;  end
                default: begin aq = {3'b000, q2};     atc = tc2;  az = z2;  end
            endcase
            total++;
            if (aq !== mon_item.q || atc !== mon_item.tc || az !== (mon_item.q == 4'd0)) begin
                bad++;
                $display("FAIL %s: got q=%0d tc=%0d zero=%0d, want q=%0d tc=%0d zero=%0d",
                         mon_item.nm, aq, atc, az, mon_item.q, mon_item.tc, (mon_item.q == 4'd0));
            end
        end
    end

    task automatic idle_all();
        en10 = 0; up10 = 0; ld10 = 0; lv10 = '0;
        en8  = 0; up8  = 0; ld8  = 0; lv8  = '0;
        en2  = 0; up2  = 0; ld2  = 0; lv2  = '0;
    endtask

    // Called at negedge+1: drive one cycle of stimulus, queue its result.
    task automatic step(input int sel, input bit e, input bit u, input bit l,
                        input int lv, input int eq, input bit etc, input string nm);
        idle_all();
        case (sel)
            0:       begin en10 = e; up10 = u; ld10 = l; lv10 = 4'(lv); end
            1:       begin en8  = e; up8  = u; ld8  = l; lv8  = 3'(lv); end
            default: begin en2  = e; up2  = u; ld2  = l; lv2  = 1'(lv); end
        endcase
        sb.push_back('{sel, 4'(eq), etc, nm});
        @(negedge clk);
        #1;
    endtask

    task automatic direct_check(input string nm, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", nm, got, want);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        idle_all();
        repeat (2) @(negedge clk);
        #1;
        direct_check("rst_q10", int'({q10, tc10, z10}), int'({4'd0, 1'b0, 1'b1}));
        direct_check("rst_q8",  int'({q8, tc8, z8}),    int'({3'd0, 1'b0, 1'b1}));
        direct_check("rst_q2",  int'({q2, tc2, z2}),    int'({1'b1, 1'b0, 1'b0}));
        reset_n = 1'b1;

        // Reach a pending tc, then reset asynchronously mid-cycle.
        step(0, 0, 0, 1, 9, 9, 0, "pre_load9");
        step(0, 1, 1, 0, 0, c_SAT ? 9 : 0, 1, "pre_wrap");
        #3 reset_n = 1'b0;
        #1;
        direct_check("async_rst", int'({q10, tc10, z10}), int'({4'd0, 1'b0, 1'b1}));
        @(negedge clk);
        #1;
        reset_n = 1'b1;

        for (int i = 1; i <= 12; i++)
            step(0, 1, 1, 0, 0, c_SAT ? ((i > 9) ? 9 : i) : (i % 10),
                 c_SAT ? (i >= 10) : (i == 10), $sformatf("up_%0d", i));

        step(0, 0, 0, 1, 2, 2, 0, "dn_load2");
        step(0, 1, 0, 0, 0, 1, 0, "dn_1");
        step(0, 1, 0, 0, 0, 0, 0, "dn_0");
        step(0, 1, 0, 0, 0, c_SAT ? 0 : 9, 1, "dn_wrap");
        step(0, 1, 0, 0, 0, c_SAT ? 0 : 8, c_SAT, "dn_after");

        step(0, 1, 1, 1, 13, 9, 0, "load_clamp13");
        step(0, 0, 0, 1, 10, 9, 0, "load_clamp10");
        step(0, 1, 0, 1, 7, 7, 0, "load_prio7");

        step(0, 0, 0, 1, 5, 5, 0, "hold_load5");
        for (int i = 0; i < 3; i++)
            step(0, 0, i[0], 0, 0, 5, 0, $sformatf("hold_%0d", i));
        step(0, 1, 1, 0, 0, 6, 0, "tog_up1");
        step(0, 1, 0, 0, 0, 5, 0, "tog_dn1");
        step(0, 1, 1, 0, 0, 6, 0, "tog_up2");
        step(0, 1, 0, 0, 0, 5, 0, "tog_dn2");

        step(0, 0, 0, 1, 8, 8, 0, "sat_load8");
        step(0, 1, 1, 0, 0, 9, 0, "sat_up1");
        step(0, 1, 1, 0, 0, c_SAT ? 9 : 0, 1, "sat_up2");
        step(0, 1, 1, 0, 0, c_SAT ? 9 : 1, c_SAT, "sat_up3");
        step(0, 0, 0, 1, 0, 0, 0, "sat_load0");
        step(0, 1, 0, 0, 0, c_SAT ? 0 : 9, 1, "sat_dn1");
        step(0, 1, 0, 0, 0, c_SAT ? 0 : 8, c_SAT, "sat_dn2");
        step(0, 0, 0, 0, 0, c_SAT ? 0 : 8, 0, "tc_clear_hold");

        for (int i = 1; i <= 9; i++)
            step(1, 1, 1, 0, 0, c_SAT ? ((i > 7) ? 7 : i) : (i % 8),
                 c_SAT ? (i >= 8) : (i == 8), $sformatf("bin_up_%0d", i));

        step(2, 1, 1, 0, 0, c_SAT ? 1 : 0, 1, "m2_up1");
        step(2, 1, 1, 0, 0, 1, c_SAT, "m2_up2");
        step(2, 1, 1, 0, 0, c_SAT ? 1 : 0, 1, "m2_up3");
        step(2, 1, 0, 0, 0, c_SAT ? 0 : 1, ~c_SAT, "m2_dn1");
        step(2, 1, 0, 0, 0, 0, c_SAT, "m2_dn2");
        step(2, 1, 1, 1, 1, 1, 0, "m2_load1");

        idle_all();
        repeat (2) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left unchecked", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
